// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
// CP0 indices, exception codes and ERET FSM states.
package cpu_pkg;

  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int EXL_BIT = 1;

  localparam logic [1:0] DRAIN_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_REDIRECT = 2'd2
  } eret_state_e;

endpackage

// File: rtl/cp0_eret_unit.sv
// CP0 Status/Cause/EPC registers and ERET sequencer.
// Drains IF/ID for a fixed depth, then redirects to EPC.
module cp0_eret_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        excptn_valid,
  input  logic [4:0]  excptn_cause,
  input  logic [31:0] excptn_pc,
  input  logic        eret_ID,
  input  logic        mtc0_en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        exl,
  output logic        eret_stall,
  output logic        eret_flush,
  output logic        load_eret_pc,
  output logic [31:0] eret_pc,
  output logic        eret_illegal
);

  eret_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;
  logic [1:0]  status_q, status_d;
  logic        stall_q, stall_d;
  logic        redir_q, redir_d;
  logic        ill_q, ill_d;
  logic        wr_status;
  logic        wr_epc;

  // Next-state for the ERET FSM and CP0 registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    status_d  = status_q;
    wr_status = mtc0_en && (cp0_addr == CP0_STATUS);
    wr_epc    = mtc0_en && (cp0_addr == CP0_EPC);
    ill_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (eret_ID && !excptn_valid) begin
          if (status_q[EXL_BIT]) begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_DEPTH;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = S_REDIRECT;
        end
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    if (wr_status) begin
      status_d = cp0_wdata[1:0];
    end
    if (state_q == S_REDIRECT) begin
      status_d[EXL_BIT] = 1'b0;
    end
    if (wr_epc) begin
      epc_d = cp0_wdata;
    end

    // Exception wins; nested ones keep the original EPC.
    if (excptn_valid) begin
      state_d           = S_IDLE;
      cnt_d             = 2'd0;
      cause_d           = excptn_cause;
      status_d[EXL_BIT] = 1'b1;
      epc_d = status_q[EXL_BIT] ? epc_q : excptn_pc;
    end

    stall_d = (state_d == S_DRAIN);
    redir_d = (state_d == S_REDIRECT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      epc_q    <= 32'd0;
      cause_q  <= 5'd0;
      status_q <= 2'd0;
      stall_q  <= 1'b0;
      redir_q  <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      status_q <= status_d;
      stall_q  <= stall_d;
      redir_q  <= redir_d;
      ill_q    <= ill_d;
    end
  end

  // Combinational CP0 read port.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      CP0_STATUS: cp0_rdata = {30'd0, status_q};
      CP0_CAUSE:  cp0_rdata = {25'd0, cause_q, 2'b00};
      CP0_EPC:    cp0_rdata = epc_q;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  assign exl          = status_q[EXL_BIT];
  assign eret_stall   = stall_q;
  assign eret_flush   = redir_q;
  assign load_eret_pc = redir_q;
  assign eret_pc      = epc_q;
  assign eret_illegal = ill_q;

endmodule
